// File: rtl/bcrypt_addr_gen.sv
// bcrypt_addr_gen: parametrised address register for one bcrypt core memory.
// Single-step opcodes plus an autonomous stride burst, all modulo WRAP_AT.
module bcrypt_addr_gen #(
    parameter int WIDTH      = 10,
    parameter int STRIDE_W   = 2,
    parameter int CNT_W      = 5,
    parameter int WRAP_AT    = 1024,
    parameter int RESET_ADDR = 1,
    parameter int CMP0       = 1022,
    parameter int CMP1       = 1023
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [2:0]          op,
    input  logic [WIDTH-1:0]    ld_addr,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                wr_b3,
    input  logic [CNT_W-1:0]    burst_len,
    output logic [WIDTH-1:0]    addr,
    output logic                busy,
    output logic                done,
    output logic                wrap,
    output logic                eq_cmp0,
    output logic                eq_cmp1
);

    localparam logic [2:0] OP_LOAD      = 3'd1;
    localparam logic [2:0] OP_INC       = 3'd2;
    localparam logic [2:0] OP_INC_B3    = 3'd3;
    localparam logic [2:0] OP_B0RST     = 3'd4;
    localparam logic [2:0] OP_ADD2B1SET = 3'd5;
    localparam logic [2:0] OP_BURST     = 3'd6;
    localparam logic [2:0] OP_ABORT     = 3'd7;

    localparam logic [WIDTH:0]   WRAP_V = (WIDTH+1)'(WRAP_AT);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_ADDR);
    localparam logic [WIDTH-1:0] CMP0_V = WIDTH'(CMP0);
    localparam logic [WIDTH-1:0] CMP1_V = WIDTH'(CMP1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_d;
    logic             done_d, wrap_d, do_step;
    logic [WIDTH:0]   base, step, sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        do_step = 1'b0;
        base    = {1'b0, addr};
        step    = (WIDTH+1)'(stride);
        unique case (state_q)
            IDLE: begin
                case (op)
                    OP_LOAD:   addr_d = ld_addr;
                    OP_INC:    do_step = 1'b1;
                    OP_INC_B3: begin
                        do_step = 1'b1;
                        step    = (WIDTH+1)'(wr_b3);
                    end
                    OP_B0RST:  addr_d = {addr[WIDTH-1:1], 1'b0};
                    // {addr[W-1:1]+1, 1} is (addr|1)+2, reusing the wrap adder
                    OP_ADD2B1SET: begin
                        do_step = 1'b1;
                        base    = {1'b0, addr[WIDTH-1:1], 1'b1};
                        step    = (WIDTH+1)'(2);
                    end
                    OP_BURST: begin
                        if (burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            cnt_d   = burst_len;
                            state_d = RUN;
                        end
                    end
                    default: ;
                endcase
            end
            RUN: begin
                if (op == OP_LOAD) begin
                    addr_d  = ld_addr;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (op == OP_ABORT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    do_step = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
        sum = base + step;
        if (do_step) begin
            if (sum >= WRAP_V) begin
                addr_d = WIDTH'(sum - WRAP_V);
                wrap_d = 1'b1;
            end else begin
                addr_d = sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr    <= RST_V;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr    <= addr_d;
            done    <= done_d;
            wrap    <= wrap_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign eq_cmp0 = (addr == CMP0_V);
    assign eq_cmp1 = (addr == CMP1_V);

endmodule

// File: tb/tb_bcrypt_addr_gen.sv
// tb_bcrypt_addr_gen: scoreboard bench over two bcrypt_addr_gen configurations.
// Driver pushes reference-model expectations; monitor pops after each edge.
module tb_bcrypt_addr_gen;

    typedef struct {
        int addr;
        bit busy;
        bit done;
        bit wrap;
        bit eq0;
        bit eq1;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [2:0] op = '0;
    logic [9:0] ld_addr = '0;
    logic [4:0] ld_small = '0;
    logic [1:0] stride = '0;
    logic       wr_b3 = 1'b0;
    logic [4:0] burst_len = '0;

    logic [9:0] a_big;
    logic       busy_b, done_b, wrap_b, eq0_b, eq1_b;
    logic [4:0] a_sm;
    logic       busy_s, done_s, wrap_s, eq0_s, eq1_s;

    int total = 0;
    int bad = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_addr[2];
    bit m_run[2];
    int m_cnt[2];

    always #5 CLK = ~CLK;

    bcrypt_addr_gen u_big (
        .CLK(CLK), .RESET(RESET), .op(op), .ld_addr(ld_addr),
        .stride(stride), .wr_b3(wr_b3), .burst_len(burst_len),
        .addr(a_big), .busy(busy_b), .done(done_b), .wrap(wrap_b),
        .eq_cmp0(eq0_b), .eq_cmp1(eq1_b)
    );

    bcrypt_addr_gen #(
        .WIDTH(5), .WRAP_AT(30), .CMP0(14), .CMP1(29)
    ) u_small (
        .CLK(CLK), .RESET(RESET), .op(op), .ld_addr(ld_small),
        .stride(stride), .wr_b3(wr_b3), .burst_len(burst_len),
        .addr(a_sm), .busy(busy_s), .done(done_s), .wrap(wrap_s),
        .eq_cmp0(eq0_s), .eq_cmp1(eq1_s)
    );

    function automatic int wrap_of(input int i);
        return (i == 0) ? 1024 : 30;
    endfunction

    function automatic int cmp0_of(input int i);
        return (i == 0) ? 1022 : 14;
    endfunction

    function automatic int cmp1_of(input int i);
        return (i == 0) ? 1023 : 29;
    endfunction

    task automatic push_exp(input int i, input bit dn, input bit wr);
        exp_t e;
        e.addr = m_addr[i];
        e.busy = m_run[i];
        e.done = dn;
        e.wrap = wr;
        e.eq0  = (m_addr[i] == cmp0_of(i));
        e.eq1  = (m_addr[i] == cmp1_of(i));
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Reference behaviour: what one clock edge does to instance i
    task automatic model_step(input int i, input int o, input int ld,
                              input int st, input int b3, input int len);
        bit dn;
        bit wr;
        bit stepped;
        int basev;
        int amt;
        int nxt;
        dn = 0;
        wr = 0;
        stepped = 0;
        amt = 0;
        basev = m_addr[i];
        if (!m_run[i]) begin
            case (o)
                1: m_addr[i] = ld;
                2: begin stepped = 1; amt = st; end
                3: begin stepped = 1; amt = b3; end
                4: m_addr[i] = m_addr[i] - (m_addr[i] % 2);
                5: begin
                    stepped = 1;
                    basev = (m_addr[i] / 2) * 2 + 1;
                    amt = 2;
                end
                6: begin
                    if (len == 0) dn = 1;
                    else begin m_run[i] = 1; m_cnt[i] = len; end
                end
                default: ;
            endcase
        end else begin
            if (o == 1) begin
                m_addr[i] = ld;
                m_run[i] = 0;
                m_cnt[i] = 0;
            end else if (o == 7) begin
                m_run[i] = 0;
                m_cnt[i] = 0;
            end else begin
                stepped = 1;
                amt = st;
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_run[i] = 0;
                    dn = 1;
                end
            end
        end
        if (stepped) begin
            nxt = basev + amt;
            if (nxt >= wrap_of(i)) begin
                nxt = nxt - wrap_of(i);
                wr = 1;
            end
            m_addr[i] = nxt;
        end
        push_exp(i, dn, wr);
    endtask

    task automatic issue(input int o, input int ld, input int st,
                         input int b3, input int len);
        @(negedge CLK);
        op        = 3'(o);
        ld_addr   = 10'(ld);
        ld_small  = 5'(ld % 30);
        stride    = 2'(st);
        wr_b3     = (b3 != 0);
        burst_len = 5'(len);
        model_step(0, o, ld, st, b3, len);
        model_step(1, o, ld % 30, st, b3, len);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 1;
            m_run[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic check_now(input string nm);
        total++;
        if (a_big !== 10'd1 || busy_b !== 1'b0 || done_b !== 1'b0 ||
            wrap_b !== 1'b0 || eq0_b !== 1'b0 || eq1_b !== 1'b0) begin
            bad++;
            $display("FAIL %s big: got addr=%0d busy=%b done=%b wrap=%b eq=%b%b, want addr=1 busy=0 done=0 wrap=0 eq=00",
                     nm, a_big, busy_b, done_b, wrap_b, eq0_b, eq1_b);
        end
        total++;
        if (a_sm !== 5'd1 || busy_s !== 1'b0 || done_s !== 1'b0 ||
            wrap_s !== 1'b0 || eq0_s !== 1'b0 || eq1_s !== 1'b0) begin
            bad++;
            $display("FAIL %s small: got addr=%0d busy=%b done=%b wrap=%b eq=%b%b, want addr=1 busy=0 done=0 wrap=0 eq=00",
                     nm, a_sm, busy_s, done_s, wrap_s, eq0_s, eq1_s);
        end
    endtask

    // Reset asserted mid-cycle, checked before the next edge, held over one edge
    task automatic do_reset_mid();
        @(negedge CLK);
        op = '0;
        model_reset();
        push_exp(0, 0, 0);
        push_exp(1, 0, 0);
        #2 RESET = 1'b1;
        #1 check_now("async_reset");
        @(negedge CLK);
        RESET = 1'b0;
        model_step(0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string nm, input exp_t e, input int a,
                       input logic bz, input logic dn, input logic wr,
                       input logic e0, input logic e1);
        total++;
        if (a !== e.addr || bz !== e.busy || dn !== e.done ||
            wr !== e.wrap || e0 !== e.eq0 || e1 !== e.eq1) begin
            bad++;
            $display("FAIL %s t=%0t: got addr=%0d busy=%b done=%b wrap=%b eq=%b%b, want addr=%0d busy=%b done=%b wrap=%b eq=%b%b",
                     nm, $time, a, bz, dn, wr, e0, e1,
                     e.addr, e.busy, e.done, e.wrap, e.eq0, e.eq1);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("big", e, int'(a_big), busy_b, done_b, wrap_b, eq0_b, eq1_b);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("small", e, int'(a_sm), busy_s, done_s, wrap_s, eq0_s, eq1_s);
            end
        end
    end

    initial begin : driver
        int o;
        int len;
        model_reset();
        #1 RESET = 1'b1;
        #12 check_now("reset");
        @(negedge CLK);
        RESET = 1'b0;

        issue(1, 1020, 0, 0, 0);
        repeat (3) issue(2, 0, 2, 0, 0);

        issue(1, 5, 0, 0, 0);
        issue(3, 0, 0, 0, 0);
        issue(3, 0, 0, 1, 0);
        issue(4, 0, 0, 0, 0);
        issue(5, 0, 0, 0, 0);

        issue(1, 1000, 0, 0, 0);
        issue(6, 0, 3, 0, 4);
        repeat (5) issue(0, 0, 3, 0, 0);

        issue(1, 28, 0, 0, 0);
        issue(6, 0, 1, 0, 3);
        repeat (4) issue(0, 0, 1, 0, 0);

        issue(6, 0, 1, 0, 6);
        issue(0, 0, 1, 0, 0);
        issue(1, 7, 1, 0, 0);
        repeat (2) issue(0, 0, 1, 0, 0);

        issue(6, 0, 2, 0, 0);
        issue(0, 0, 2, 0, 0);

        issue(6, 0, 1, 0, 2);
        repeat (2) issue(0, 0, 1, 0, 0);
        issue(6, 0, 2, 0, 3);
        repeat (4) issue(2, 0, 2, 0, 0);

        issue(6, 0, 3, 0, 5);
        issue(0, 0, 3, 0, 0);
        issue(7, 0, 3, 0, 0);
        issue(0, 0, 3, 0, 0);

        issue(1, 1000, 0, 0, 0);
        issue(6, 0, 2, 0, 10);
        repeat (3) issue(0, 0, 2, 0, 0);
        do_reset_mid();

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset_mid();
            end else begin
                if (m_run[0]) begin
                    case ($urandom_range(0, 19))
                        0: o = 1;
                        1: o = 7;
                        default: o = $urandom_range(0, 6);
                    endcase
                end else begin
                    o = $urandom_range(0, 7);
                end
                len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
                issue(o, $urandom_range(0, 1023), $urandom_range(0, 3),
                      $urandom_range(0, 1), len);
            end
        end

        @(negedge CLK);
        op = '0;
        repeat (2) @(negedge CLK);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcrypt_addr_gen.md
# bcrypt_addr_gen

Parametrised address-generator register for the bcrypt core: the next generation of the per-memory address registers (S, P/N, PD). One instance drives the address of one core memory. It adds configurable width, stride and wrap modulus, keeps the existing single-step opcodes, and adds an autonomous burst mode that steps the address for N cycles without per-cycle opcodes.

## Interface
Parameters:
- WIDTH, 10, address width in bits.
- STRIDE_W, 2, width of the stride input.
- CNT_W, 5, width of the burst length and counter.
- WRAP_AT, 1024, address modulus; legal range 2..2^WIDTH.
- RESET_ADDR, 1, address value after reset.
- CMP0, 1022, first compare constant.
- CMP1, 1023, second compare constant.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- op  in  3  opcode: 0 NOP, 1 LOAD, 2 INC, 3 INC_B3, 4 B0RST, 5 ADD2B1SET, 6 BURST, 7 ABORT.
- ld_addr  in  WIDTH  value for LOAD; must be < WRAP_AT.
- stride  in  STRIDE_W  step for INC and BURST; sampled every cycle.
- wr_b3  in  1  conditional increment for INC_B3.
- burst_len  in  CNT_W  number of steps for BURST; sampled with op=BURST.
- addr  out  WIDTH  current address (register).
- busy  out  1  high while a burst is running (register).
- done  out  1  one-cycle pulse at burst end (register).
- wrap  out  1  one-cycle pulse in the cycle after any step that wrapped (register).
- eq_cmp0  out  1  addr == CMP0 (combinational from addr).
- eq_cmp1  out  1  addr == CMP1 (combinational from addr).

## Operation
Step arithmetic:
- sum = addr + step, computed in WIDTH+1 bits.
- If sum ≥ WRAP_AT: next = sum − WRAP_AT and wrap is set next cycle. Otherwise next = sum.

FSM states: IDLE, RUN.

In IDLE, opcodes act as follows:
- LOAD: addr ← ld_addr.
- INC: step = stride.
- INC_B3: step = wr_b3.
- B0RST: clear addr[0].
- ADD2B1SET: addr ← {addr[W-1:1]+1, 1}, with wrap applied to the result.
- NOP / ABORT: no change.
- BURST, burst_len = 0: no step; done pulses next cycle; stay IDLE.
- BURST, burst_len = L > 0: load cnt ← L and go to RUN. The BURST cycle itself performs no step.

In RUN, each cycle:
- addr steps by stride and cnt decrements.
- When cnt reaches 1 and steps, go to IDLE and set done for one cycle.
- LOAD in RUN: addr ← ld_addr, cnt cleared, go to IDLE, no done. LOAD has priority over the step.
- ABORT in RUN: no step, go to IDLE, no done.
- All other opcodes in RUN are ignored.

Other rules:
- busy = (state == RUN).
- wrap and done are cleared every cycle unless set.
- Reset is asynchronous and may arrive mid-burst. It forces: addr = RESET_ADDR, state IDLE, cnt = 0, busy = 0, done = 0, wrap = 0.

## Timing
- Every opcode takes effect at the rising edge where it is sampled. addr is valid in the following cycle.
- eq_cmp0 / eq_cmp1 follow addr in the same cycle, with zero added latency.
- A BURST of L issued in cycle t:
  - busy is high in cycles t+1 .. t+L.
  - addr takes values base+s, base+2s, … in cycles t+2 .. t+L+1.
  - done is high in cycle t+L+1, and busy is low in that cycle.
- A new BURST may be issued in the same cycle done is high.
- Back-to-back single-step opcodes have a throughput of 1 per cycle.
- Stride change during RUN takes effect on the next step. No latching.
- Reset values: addr = RESET_ADDR; busy, done and wrap = 0. eq flags follow RESET_ADDR (defaults: eq_cmp0 = 0, eq_cmp1 = 0).

## Test plan
- Reset with default parameters → addr = 1, busy = 0, done = 0, wrap = 0. Assert RESET mid-burst → same values asynchronously, before the next edge.
- LOAD 1020, then INC stride 2 three times → addr 1022 (eq_cmp0 = 1), then 0 with wrap pulse, then 2.
- LOAD 5, INC_B3 with wr_b3 = 0 then 1 → 5, 6. Then B0RST → 6. Then ADD2B1SET → 9.
- LOAD 1000, BURST len 4 stride 3 at cycle t → busy high t+1..t+4, addr 1003/1006/1009/1012 at t+2..t+5, done only at t+5.
- Parameters WRAP_AT = 30, WIDTH = 5: LOAD 28, BURST len 3 stride 1 → addr 29, 0 (wrap pulse), 1; eq flags checked against CMP0 = 14, CMP1 = 29.
- BURST len 6, then LOAD 7 on the second RUN cycle → addr = 7, busy low next cycle, no done. Separately, BURST len 0 → done pulse next cycle, addr unchanged.
